quick_spi_slave: RTL and testbench
==================================

QUICK_SPI_SLAVE -- requirements
Module: quick_spi_slave

Interface
REQ-001 SHALL have parameter RX_DATA_WIDTH, default 16: MOSI bits captured per frame (1..64).
REQ-002 SHALL have parameter TX_DATA_WIDTH, default 8: MISO bits driven per frame (1..64).
REQ-003 SHALL have parameter CPOL, default 0: SCLK idle level.
REQ-004 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 SHALL have parameter BITS_ORDER, default 1: 1 = MSB first, 0 = LSB first, for both directions.
REQ-006 SHALL have parameter MISO_IDLE_VALUE, default 1'b0: MISO level outside data bits.
REQ-007 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-008 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port enable, input, 1: frame starts are accepted only while high.
REQ-010 SHALL have port ss_n, input, 1: slave select, active low, asynchronous to clk.
REQ-011 SHALL have port sclk, input, 1: SPI clock, asynchronous to clk.
REQ-012 SHALL have port mosi, input, 1: master-out data.
REQ-013 SHALL have port miso, output, 1: slave-out data.
REQ-014 SHALL have port miso_oe, output, 1: high while selected; drives the external tristate.
REQ-015 SHALL have port tx_data, input, TX_DATA_WIDTH: response word, sampled at frame start.
REQ-016 SHALL have port rx_data, output, RX_DATA_WIDTH: last received word, held until the next valid frame.
REQ-017 SHALL have port rx_valid, output, 1: one-clk pulse when rx_data is updated.
REQ-018 SHALL have port busy, output, 1: high in ACTIVE.

Function
REQ-019 ss_n, sclk and mosi SHALL pass through 2-flop synchronizers; edges are detected on the synchronized signals, giving 3 clk latency from pin to action; clk SHALL be at least 4x sclk.
REQ-020 The state machine SHALL have states IDLE, ACTIVE and DONE; reset enters IDLE.
REQ-021 IDLE -> ACTIVE on a synchronized ss_n falling edge with enable=1; tx_data latched into the TX shift register and bit counters cleared in that cycle.
REQ-022 A leading edge is an sclk transition away from CPOL; the trailing edge is the return to CPOL.
REQ-023 On each sample edge (leading if CPHA=0, else trailing) the synchronized mosi SHALL shift into the RX register in BITS_ORDER while rx_count < RX_DATA_WIDTH; further bits SHALL be ignored, since the master's extra toggles are legal.
REQ-024 With CPHA=0, the first TX bit SHALL drive miso in the ACTIVE-entry cycle and advance on each trailing edge; with CPHA=1, it advances on each leading edge.
REQ-025 After TX_DATA_WIDTH bits have been driven, miso SHALL be MISO_IDLE_VALUE for the rest of the frame.
REQ-026 ACTIVE -> DONE on a synchronized ss_n rising edge; DONE -> IDLE after one clk.
REQ-027 In DONE, if rx_count == RX_DATA_WIDTH, rx_data SHALL load the RX register and rx_valid SHALL pulse; otherwise (short frame) rx_data SHALL be kept and there SHALL be no pulse.
REQ-028 An ss_n fall while enable=0 SHALL be ignored for the whole frame; enable dropping mid-frame SHALL NOT abort it.
REQ-029 Outside ACTIVE: miso = MISO_IDLE_VALUE and miso_oe = 0.
REQ-030 Counters SHALL saturate and never wrap, for any number of sclk toggles.

Reset
REQ-031 reset_n low SHALL asynchronously force: state IDLE, rx_data 0, rx_valid 0, busy 0, miso MISO_IDLE_VALUE, miso_oe 0, shift registers, counters and synchronizers cleared (ss_n synchronizer to 1, sclk synchronizer to CPOL).
REQ-032 Reset mid-frame SHALL discard the frame; a frame already in progress at release SHALL NOT be accepted until ss_n is seen high and then falls again.

Configuration
REQ-033 With QUICK_SPI_SLAVE_ERROR_CHECK_EN defined: output frame_error (1 bit) SHALL pulse in DONE for a short frame, and output error_count (8 bits) SHALL count such frames, saturating at 255 and cleared by reset.
REQ-034 Without QUICK_SPI_SLAVE_ERROR_CHECK_EN: neither port exists and short frames are silently dropped.

Verification
REQ-035 Mode 0, MSB first, RX 16 / TX 8: master sends 0xA55A with tx_data=0x3C -> rx_data=0xA55A, one rx_valid pulse, miso bits 0,0,1,1,1,1,0,0.
REQ-036 Mode 0, LSB first: master sends 0x0001 -> rx_data=0x0001; tx_data=0x81 -> miso 1,0,0,0,0,0,0,1.
REQ-037 CPOL=1, CPHA=1: 16 bits plus 6 extra toggles of 0x1234 -> rx_data=0x1234, extra bits ignored, miso idle after bit 8.
REQ-038 ss_n rises after 9 bits -> no rx_valid, rx_data unchanged; with the macro, frame_error pulses once and error_count goes 0 -> 1.
REQ-039 reset_n asserted after bit 5 -> outputs at reset values immediately; next full frame of 0xFFFF -> rx_data=0xFFFF.
REQ-040 enable=0 at ss_n fall, with enable raised mid-frame -> frame ignored, busy stays 0, miso_oe stays 0.

Source files
------------

// File: rtl/quick_spi_slave.sv
// SPI slave with 2-flop input synchronizers, independent RX/TX frame widths and CPOL/CPHA modes.
// Optional short-frame reporting (frame_error, error_count) when QUICK_SPI_SLAVE_ERROR_CHECK_EN is defined.
module quick_spi_slave #(
  parameter int RX_DATA_WIDTH   = 16,
  parameter int TX_DATA_WIDTH   = 8,
  parameter bit CPOL            = 1'b0,
  parameter bit CPHA            = 1'b0,
  parameter bit BITS_ORDER      = 1'b1,
  parameter bit MISO_IDLE_VALUE = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     ss_n,
  input  logic                     sclk,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe,
  input  logic [TX_DATA_WIDTH-1:0] tx_data,
  output logic [RX_DATA_WIDTH-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     busy
`ifdef QUICK_SPI_SLAVE_ERROR_CHECK_EN
  ,
  output logic                     frame_error,
  output logic [7:0]               error_count
`endif
);

  localparam int RCW = $clog2(RX_DATA_WIDTH + 1);
  localparam int TCW = $clog2(TX_DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                   state;
  logic [1:0]               ss_sync, sclk_sync, mosi_sync;
  logic                     ss_prev, sclk_prev;
  logic [1:0]               init_q;
  logic                     armed;
  logic [RX_DATA_WIDTH-1:0] rx_sh;
  logic [TX_DATA_WIDTH-1:0] tx_sh;
  logic [RCW-1:0]           rx_count;
  logic [TCW-1:0]           tx_count;

  logic ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, lead, trail, sample_edge, shift_edge;

  function automatic logic tx_bit(input logic [TX_DATA_WIDTH-1:0] v);
    return BITS_ORDER ? v[TX_DATA_WIDTH-1] : v[0];
  endfunction

  function automatic logic [TX_DATA_WIDTH-1:0] tx_next(input logic [TX_DATA_WIDTH-1:0] v);
    return BITS_ORDER ? (v << 1) : (v >> 1);
  endfunction

  function automatic logic [RX_DATA_WIDTH-1:0] rx_next(input logic [RX_DATA_WIDTH-1:0] v,
                                                       input logic b);
    return BITS_ORDER ? ((v << 1) | RX_DATA_WIDTH'(b))
                      : ((v >> 1) | (RX_DATA_WIDTH'(b) << (RX_DATA_WIDTH - 1)));
  endfunction

  assign ss_s        = ss_sync[1];
  assign sclk_s      = sclk_sync[1];
  assign mosi_s      = mosi_sync[1];
  // A fall only counts once ss_n has really been seen high since reset.
  assign ss_fall     = armed & ss_prev & ~ss_s;
  assign ss_rise     = ~ss_prev & ss_s;
  assign lead        = (sclk_prev == CPOL) && (sclk_s != CPOL);
  assign trail       = (sclk_prev != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_sync   <= 2'b11;
      sclk_sync <= {2{CPOL}};
      mosi_sync <= 2'b00;
      ss_prev   <= 1'b1;
      sclk_prev <= CPOL;
      init_q    <= 2'b00;
      armed     <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[0], ss_n};
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      ss_prev   <= ss_s;
      sclk_prev <= sclk_s;
      // init_q[1] marks that ss_sync[1] now holds a genuine pin sample.
      init_q    <= {init_q[0], 1'b1};
      armed     <= armed | (init_q[1] & ss_s);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      miso     <= MISO_IDLE_VALUE;
      miso_oe  <= 1'b0;
      rx_sh    <= '0;
      tx_sh    <= '0;
      rx_count <= '0;
      tx_count <= '0;
`ifdef QUICK_SPI_SLAVE_ERROR_CHECK_EN
      frame_error <= 1'b0;
      error_count <= 8'd0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef QUICK_SPI_SLAVE_ERROR_CHECK_EN
      frame_error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ss_fall && enable) begin
            state    <= ACTIVE;
            busy     <= 1'b1;
            miso_oe  <= 1'b1;
            rx_sh    <= '0;
            rx_count <= '0;
            if (!CPHA) begin
              miso     <= tx_bit(tx_data);
              tx_sh    <= tx_next(tx_data);
              tx_count <= TCW'(1);
            end else begin
              miso     <= MISO_IDLE_VALUE;
              tx_sh    <= tx_data;
              tx_count <= '0;
            end
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state   <= DONE;
            busy    <= 1'b0;
            miso_oe <= 1'b0;
            miso    <= MISO_IDLE_VALUE;
          end else begin
            if (sample_edge && (rx_count < RCW'(RX_DATA_WIDTH))) begin
              rx_sh    <= rx_next(rx_sh, mosi_s);
              rx_count <= rx_count + 1'b1;
            end
            if (shift_edge) begin
              if (tx_count < TCW'(TX_DATA_WIDTH)) begin
                miso     <= tx_bit(tx_sh);
                tx_sh    <= tx_next(tx_sh);
                tx_count <= tx_count + 1'b1;
              end else begin
                miso <= MISO_IDLE_VALUE;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          if (rx_count == RCW'(RX_DATA_WIDTH)) begin
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
          end
`ifdef QUICK_SPI_SLAVE_ERROR_CHECK_EN
          else begin
            frame_error <= 1'b1;
            if (error_count != 8'hFF) error_count <= error_count + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quick_spi_slave.sv
// Directed bench: three slaves (mode 0 MSB, mode 0 LSB, mode 3 MSB) driven by a bit-banged master.
module tb_quick_spi_slave;

  localparam int HALF = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [2:0]       ss_n, sclk, mosi, miso, oe, busy, rv;
  logic [2:0][7:0]  txd;
  logic [2:0][15:0] rxd;
`ifdef QUICK_SPI_SLAVE_ERROR_CHECK_EN
  logic [2:0]       fe;
  logic [2:0][7:0]  ec;
  int               fcnt = 0;
`endif

  int checks = 0;
  int errs   = 0;
  int vcnt [3];
  bit act_seen;

  always #5 clk = ~clk;

  quick_spi_slave #(.RX_DATA_WIDTH(16), .TX_DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0),
                    .BITS_ORDER(1'b1), .MISO_IDLE_VALUE(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ss_n(ss_n[0]), .sclk(sclk[0]),
    .mosi(mosi[0]), .miso(miso[0]), .miso_oe(oe[0]), .tx_data(txd[0]), .rx_data(rxd[0]),
    .rx_valid(rv[0]), .busy(busy[0])
`ifdef QUICK_SPI_SLAVE_ERROR_CHECK_EN
    , .frame_error(fe[0]), .error_count(ec[0])
`endif
  );

  quick_spi_slave #(.RX_DATA_WIDTH(16), .TX_DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0),
                    .BITS_ORDER(1'b0), .MISO_IDLE_VALUE(1'b0)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ss_n(ss_n[1]), .sclk(sclk[1]),
    .mosi(mosi[1]), .miso(miso[1]), .miso_oe(oe[1]), .tx_data(txd[1]), .rx_data(rxd[1]),
    .rx_valid(rv[1]), .busy(busy[1])
`ifdef QUICK_SPI_SLAVE_ERROR_CHECK_EN
    , .frame_error(fe[1]), .error_count(ec[1])
`endif
  );

  quick_spi_slave #(.RX_DATA_WIDTH(16), .TX_DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1),
                    .BITS_ORDER(1'b1), .MISO_IDLE_VALUE(1'b0)) u2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ss_n(ss_n[2]), .sclk(sclk[2]),
    .mosi(mosi[2]), .miso(miso[2]), .miso_oe(oe[2]), .tx_data(txd[2]), .rx_data(rxd[2]),
    .rx_valid(rv[2]), .busy(busy[2])
`ifdef QUICK_SPI_SLAVE_ERROR_CHECK_EN
    , .frame_error(fe[2]), .error_count(ec[2])
`endif
  );

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) if (rv[k]) vcnt[k]++;
    if (busy[0] || oe[0]) act_seen = 1'b1;
`ifdef QUICK_SPI_SLAVE_ERROR_CHECK_EN
    if (fe[0]) fcnt++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // exp_miso lists the expected miso bits left to right in wire order.
  task automatic xfer(input int d, input bit cpol, input bit cpha, input bit msb,
                      input logic [15:0] word, input int nbits, input logic [7:0] exp_miso,
                      input bit chk_miso, input bit end_frame);
    ss_n[d] = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      automatic logic b = (i < 16) ? (msb ? word[15-i] : word[i]) : 1'b1;
      if (!cpha) begin
        mosi[d] = b;
        wait_clk(HALF);
      end else begin
        sclk[d] = ~cpol;
        mosi[d] = b;
        wait_clk(HALF);
      end
      if (chk_miso) begin
        if (i == 0) chk($sformatf("oe%0d_active", d), 32'(oe[d]), 32'd1);
        chk($sformatf("miso%0d_bit%0d", d, i), 32'(miso[d]),
            (i < 8) ? 32'(exp_miso[7-i]) : 32'd0);
      end
      if (!cpha) begin
        sclk[d] = ~cpol;
        wait_clk(HALF);
        sclk[d] = cpol;
      end else begin
        sclk[d] = cpol;
        wait_clk(HALF);
      end
    end
    if (end_frame) begin
      wait_clk(HALF);
      ss_n[d] = 1'b1;
      wait_clk(HALF);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    ss_n    = 3'b111;
    sclk    = 3'b100;
    mosi    = 3'b000;
    txd     = '0;
    wait_clk(4);
    chk("rst_rx_data", 32'(rxd[0]), 32'h0);
    chk("rst_rx_valid", 32'(rv[0]), 32'h0);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    chk("rst_miso", 32'(miso[0]), 32'h0);
    chk("rst_miso_oe", 32'(oe[0]), 32'h0);
`ifdef QUICK_SPI_SLAVE_ERROR_CHECK_EN
    chk("rst_err_cnt", 32'(ec[0]), 32'h0);
`endif
    reset_n = 1'b1;
    wait_clk(10);

    // Mode 0 MSB first
    txd[0] = 8'h3C; vcnt[0] = 0;
    xfer(0, 1'b0, 1'b0, 1'b1, 16'hA55A, 16, 8'b00111100, 1'b1, 1'b1);
    chk("m0_rx_data", 32'(rxd[0]), 32'hA55A);
    chk("m0_rx_valid_cnt", vcnt[0], 32'd1);
    chk("m0_busy_after", 32'(busy[0]), 32'h0);
    chk("m0_oe_after", 32'(oe[0]), 32'h0);

    // Mode 0 LSB first
    txd[1] = 8'h81; vcnt[1] = 0;
    xfer(1, 1'b0, 1'b0, 1'b0, 16'h0001, 16, 8'b10000001, 1'b1, 1'b1);
    chk("lsb_rx_data", 32'(rxd[1]), 32'h0001);
    chk("lsb_rx_valid_cnt", vcnt[1], 32'd1);

    // CPOL=1 CPHA=1 with 6 extra toggles
    txd[2] = 8'hA6; vcnt[2] = 0;
    xfer(2, 1'b1, 1'b1, 1'b1, 16'h1234, 22, 8'b10100110, 1'b1, 1'b1);
    chk("m3_rx_data", 32'(rxd[2]), 32'h1234);
    chk("m3_rx_valid_cnt", vcnt[2], 32'd1);

    // Short frame: 9 bits
    vcnt[0] = 0;
    xfer(0, 1'b0, 1'b0, 1'b1, 16'h0F0F, 9, 8'b00111100, 1'b1, 1'b1);
    chk("short_rx_data", 32'(rxd[0]), 32'hA55A);
    chk("short_rx_valid_cnt", vcnt[0], 32'd0);
`ifdef QUICK_SPI_SLAVE_ERROR_CHECK_EN
    chk("short_frame_err_cnt", fcnt, 32'd1);
    chk("short_err_count", 32'(ec[0]), 32'd1);
`endif

    // Reset after bit 5, with ss_n still low across the release
    xfer(0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 5, 8'b00111100, 1'b0, 1'b0);
    chk("midrst_busy_before", 32'(busy[0]), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("midrst_rx_data", 32'(rxd[0]), 32'h0);
    chk("midrst_busy", 32'(busy[0]), 32'h0);
    chk("midrst_oe", 32'(oe[0]), 32'h0);
    chk("midrst_miso", 32'(miso[0]), 32'h0);
    chk("midrst_rx_valid", 32'(rv[0]), 32'h0);
    wait_clk(3);
    reset_n = 1'b1;
    act_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sclk[0] = 1'b1; wait_clk(HALF);
      sclk[0] = 1'b0; wait_clk(HALF);
    end
    chk("postrst_no_accept", 32'(act_seen), 32'h0);
    ss_n[0] = 1'b1;
    wait_clk(10);
    vcnt[0] = 0;
    xfer(0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16, 8'b00111100, 1'b1, 1'b1);
    chk("postrst_rx_data", 32'(rxd[0]), 32'hFFFF);
    chk("postrst_rx_valid_cnt", vcnt[0], 32'd1);

    // enable low at ss_n fall, raised mid-frame
    enable = 1'b0;
    act_seen = 1'b0; vcnt[0] = 0;
    ss_n[0] = 1'b0;
    wait_clk(6);
    enable = 1'b1;
    xfer(0, 1'b0, 1'b0, 1'b1, 16'h1111, 16, 8'h00, 1'b0, 1'b1);
    chk("disabled_no_activity", 32'(act_seen), 32'h0);
    chk("disabled_rx_data", 32'(rxd[0]), 32'hFFFF);
    chk("disabled_rx_valid_cnt", vcnt[0], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
